weight_tile_addr_gen: RTL

WEIGHT_TILE_ADDR_GEN -- requirements
Module: weight_tile_addr_gen

---
 rtl/weight_tile_addr_gen_if.sv | 31 +++
 rtl/weight_tile_addr_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/weight_tile_addr_gen_if.sv
// Handshake and configuration bundle between a weight-tile address consumer and
// weight_tile_addr_gen.
interface weight_tile_addr_gen_if #(
   parameter int ADDR_W = 16,
   parameter int K_W    = 16,
   parameter int M_W    = 12,
   parameter int R_W    = 12
);
   logic              start;
   logic [ADDR_W-1:0] cfg_base;
   logic [K_W-1:0]    cfg_k;
   logic [M_W-1:0]    cfg_m;
   logic [R_W-1:0]    cfg_reuse;
   logic              i_ready;
   logic              o_valid;
   logic [ADDR_W-1:0] o_addr;
   logic              o_pad;
   logic              o_tile_last;
   logic              o_busy;
   logic              o_done;

   modport master (
      output start, cfg_base, cfg_k, cfg_m, cfg_reuse, i_ready,
      input  o_valid, o_addr, o_pad, o_tile_last, o_busy, o_done
   );

   modport slave (
      input  start, cfg_base, cfg_k, cfg_m, cfg_reuse, i_ready,
      output o_valid, o_addr, o_pad, o_tile_last, o_busy, o_done
   );
endinterface

// File: rtl/weight_tile_addr_gen.sv
// Walks an MxK weight matrix in TILExTILE tiles (band, pass, column tile, row, column),
// emitting one address per handshake and zero-fill flags outside the matrix.
module weight_tile_addr_gen #(
   parameter int TILE   = 8,
   parameter int ADDR_W = 16,
   parameter int K_W    = 16,
   parameter int M_W    = 12,
   parameter int R_W    = 12
) (
   input logic                clk,
   input logic                rstn,
   weight_tile_addr_gen_if.slave bus
);
   localparam int LG = $clog2(TILE);
   localparam int RW = M_W + 1;
   localparam int CW = K_W + 1;
   localparam logic [LG-1:0] IMAX = LG'(TILE - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
   state_t state_r;

   logic [K_W-1:0]    k_r;
   logic [M_W-1:0]    m_r;
   logic [R_W-1:0]    reuse_r, p_r;
   logic [ADDR_W-1:0] k_step_r, band_step_r, band_ptr_r, tile_ptr_r, row_ptr_r;
   logic [RW-1:0]     row_base_r;
   logic [CW-1:0]     col_base_r;
   logic [LG-1:0]     i_r, j_r;

   logic [LG-1:0]     i_s, j_s;
   logic [R_W-1:0]    p_s;
   logic [RW-1:0]     row_base_s;
   logic [CW-1:0]     col_base_s;
   logic [ADDR_W-1:0] band_ptr_s, tile_ptr_s, row_ptr_s, addr_s;
   logic              pad_s, tile_last_s, last_elem_s, cfg_zero_s;
   logic              last_j_s, last_i_s, last_tc_s, last_p_s, last_tr_s;

   // Next traversal position: pointers step by +1, +K, +TILE or +TILE*K only.
   always_comb begin
      last_j_s    = (j_r == IMAX);
      last_i_s    = (i_r == IMAX);
      last_tc_s   = ((col_base_r + CW'(TILE)) >= CW'(k_r));
      last_p_s    = (p_r == (reuse_r - R_W'(1)));
      last_tr_s   = ((row_base_r + RW'(TILE)) >= RW'(m_r));
      last_elem_s = last_j_s && last_i_s && last_tc_s && last_p_s && last_tr_s;
      cfg_zero_s  = (bus.cfg_k == '0) || (bus.cfg_m == '0) || (bus.cfg_reuse == '0);
      i_s         = i_r;
      j_s         = j_r;
      p_s         = p_r;
      row_base_s  = row_base_r;
      col_base_s  = col_base_r;
      band_ptr_s  = band_ptr_r;
      tile_ptr_s  = tile_ptr_r;
      row_ptr_s   = row_ptr_r;
      if (!last_j_s) begin
         j_s = j_r + LG'(1);
      end else begin
         j_s = '0;
         if (!last_i_s) begin
            i_s       = i_r + LG'(1);
            row_ptr_s = row_ptr_r + k_step_r;
         end else begin
            i_s = '0;
            if (!last_tc_s) begin
               col_base_s = col_base_r + CW'(TILE);
               tile_ptr_s = tile_ptr_r + ADDR_W'(TILE);
               row_ptr_s  = tile_ptr_r + ADDR_W'(TILE);
            end else begin
               col_base_s = '0;
               if (!last_p_s) begin
                  p_s        = p_r + R_W'(1);
                  tile_ptr_s = band_ptr_r;
                  row_ptr_s  = band_ptr_r;
               end else begin
                  p_s        = '0;
                  row_base_s = row_base_r + RW'(TILE);
                  band_ptr_s = band_ptr_r + band_step_r;
                  tile_ptr_s = band_ptr_r + band_step_r;
                  row_ptr_s  = band_ptr_r + band_step_r;
               end
            end
         end
      end
      pad_s       = ((row_base_s + RW'(i_s)) >= RW'(m_r)) || ((col_base_s + CW'(j_s)) >= CW'(k_r));
      addr_s      = pad_s ? '0 : (row_ptr_s + ADDR_W'(j_s));
      tile_last_s = (i_s == IMAX) && (j_s == IMAX);
   end

   // Job FSM, traversal registers and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r         <= IDLE;
         k_r             <= '0;
         m_r             <= '0;
         reuse_r         <= '0;
         p_r             <= '0;
         k_step_r        <= '0;
         band_step_r     <= '0;
         band_ptr_r      <= '0;
         tile_ptr_r      <= '0;
         row_ptr_r       <= '0;
         row_base_r      <= '0;
         col_base_r      <= '0;
         i_r             <= '0;
         j_r             <= '0;
         bus.o_valid     <= 1'b0;
         bus.o_addr      <= '0;
         bus.o_pad       <= 1'b0;
         bus.o_tile_last <= 1'b0;
         bus.o_busy      <= 1'b0;
         bus.o_done      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  k_r         <= bus.cfg_k;
                  m_r         <= bus.cfg_m;
                  reuse_r     <= bus.cfg_reuse;
                  k_step_r    <= ADDR_W'(bus.cfg_k);
                  band_step_r <= ADDR_W'(bus.cfg_k) << LG;
                  band_ptr_r  <= bus.cfg_base;
                  tile_ptr_r  <= bus.cfg_base;
                  row_ptr_r   <= bus.cfg_base;
                  p_r         <= '0;
                  row_base_r  <= '0;
                  col_base_r  <= '0;
                  i_r         <= '0;
                  j_r         <= '0;
                  bus.o_busy  <= 1'b1;
                  bus.o_pad   <= 1'b0;
                  bus.o_tile_last <= 1'b0;
                  if (cfg_zero_s) begin
                     state_r     <= DONE;
                     bus.o_done  <= 1'b1;
                     bus.o_valid <= 1'b0;
                     bus.o_addr  <= '0;
                  end else begin
                     state_r     <= RUN;
                     bus.o_done  <= 1'b0;
                     bus.o_valid <= 1'b1;
                     bus.o_addr  <= bus.cfg_base;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               if (bus.o_valid && bus.i_ready) begin
                  if (last_elem_s) begin
                     state_r         <= DONE;
                     bus.o_valid     <= 1'b0;
                     bus.o_addr      <= '0;
                     bus.o_pad       <= 1'b0;
                     bus.o_tile_last <= 1'b0;
                     bus.o_done      <= 1'b1;
                  end else begin
                     i_r             <= i_s;
                     j_r             <= j_s;
                     p_r             <= p_s;
                     row_base_r      <= row_base_s;
                     col_base_r      <= col_base_s;
                     band_ptr_r      <= band_ptr_s;
                     tile_ptr_r      <= tile_ptr_s;
                     row_ptr_r       <= row_ptr_s;
                     bus.o_addr      <= addr_s;
                     bus.o_pad       <= pad_s;
                     bus.o_tile_last <= tile_last_s;
                  end
               end else begin
                  state_r <= RUN;
               end
            end
            DONE: begin
               state_r     <= IDLE;
               bus.o_done  <= 1'b0;
               bus.o_busy  <= 1'b0;
               bus.o_valid <= 1'b0;
            end
            default: begin
               state_r         <= IDLE;
               bus.o_valid     <= 1'b0;
               bus.o_addr      <= '0;
               bus.o_pad       <= 1'b0;
               bus.o_tile_last <= 1'b0;
               bus.o_busy      <= 1'b0;
               bus.o_done      <= 1'b0;
            end
         endcase
      end
   end
endmodule
